// File: rtl/kamacore_pipeline_chain.sv
// rtl/kamacore_pipeline_chain.sv - parametrised valid/ready pipeline register chain
//
// Purpose: carries a DATA_W-bit payload through NUM_STAGES registered stages.
// Each stage has its own stall and flush controls. Empty stages collapse
// bubbles, and both ends use a valid/ready handshake. Stage 0 is the
// youngest stage and NUM_STAGES-1 is the oldest.
//
// Ports:
//   i_clk, i_rst     clock (rising edge), asynchronous active-high reset
//   i_hold           global freeze; no stage loads, but flush still applies
//   i_in_valid       upstream offers i_in_data
//   o_in_ready       stage 0 accepts this cycle (combinational)
//   i_in_data        payload entering stage 0
//   i_stall          per-stage: stage i may not pass its contents forward
//   i_flush          per-stage: stage i is emptied at the next edge
//   o_out_valid      oldest stage presents o_out_data
//   i_out_ready      sink accepts o_out_data
//   o_out_data       payload of the oldest stage
//   o_stage_valid    registered valid bit of each stage
//   o_occupancy      popcount of o_stage_valid
module kamacore_pipeline_chain #(
  parameter int DATA_W     = 32,
  parameter int NUM_STAGES = 4,
  localparam int OCC_W     = $clog2(NUM_STAGES + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_hold,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_W-1:0]     i_in_data,
  input  logic [NUM_STAGES-1:0] i_stall,
  input  logic [NUM_STAGES-1:0] i_flush,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_W-1:0]     o_out_data,
  output logic [NUM_STAGES-1:0] o_stage_valid,
  output logic [OCC_W-1:0]      o_occupancy
);

  logic [NUM_STAGES-1:0] r_valid;
  logic [DATA_W-1:0]     r_data [NUM_STAGES];

  // w_acc[i]: stage i can take a new beat at the next edge.
  // w_acc[NUM_STAGES] is the sink.
  logic [NUM_STAGES:0]   w_acc;
  logic [NUM_STAGES-1:0] w_fire;
  logic [NUM_STAGES-1:0] w_inc_valid;
  logic [DATA_W-1:0]     w_inc_data [NUM_STAGES];

  // Ready ripples from the oldest stage back to the youngest. A stage that
  // is empty, or that is being flushed, accepts regardless of what lies
  // downstream. This is what closes gaps behind a stall.
  always_comb begin
    w_acc              = '0;
    w_fire             = '0;
    w_acc[NUM_STAGES]  = i_out_ready;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      w_fire[i] = r_valid[i] & ~i_stall[i] & ~i_flush[i] & w_acc[i+1] & ~i_hold;
      w_acc[i]  = ~i_hold & (~r_valid[i] | w_fire[i] | i_flush[i]);
    end
  end

  always_comb begin
    w_inc_valid    = '0;
    w_inc_valid[0] = i_in_valid & w_acc[0];
    w_inc_data[0]  = i_in_data;
    for (int i = 1; i < NUM_STAGES; i++) begin
      w_inc_valid[i] = w_fire[i-1];
      w_inc_data[i]  = r_data[i-1];
    end
  end

  // Flush takes priority. A beat arriving at a flushed stage still
  // completes its handshake (w_acc is high), and is then dropped here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (i_flush[i]) begin
          r_valid[i] <= 1'b0;
        end else if (w_acc[i]) begin
          r_valid[i] <= w_inc_valid[i];
          if (w_inc_valid[i]) begin
            r_data[i] <= w_inc_data[i];
          end
        end
      end
    end
  end

  assign o_in_ready    = w_acc[0];
  assign o_out_valid   = r_valid[NUM_STAGES-1] & ~i_stall[NUM_STAGES-1]
                       & ~i_flush[NUM_STAGES-1] & ~i_hold;
  assign o_out_data    = r_data[NUM_STAGES-1];
  assign o_stage_valid = r_valid;

  always_comb begin
    o_occupancy = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      o_occupancy = o_occupancy + OCC_W'(r_valid[i]);
    end
  end

endmodule

// File: tb/tb_kamacore_pipeline_chain.sv
// tb/tb_kamacore_pipeline_chain.sv - scoreboard bench for kamacore_pipeline_chain
module tb_kamacore_pipeline_chain;
  localparam int N = 4;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         hold, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic [N-1:0] stall, flush;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [N-1:0] stage_valid;
  logic [2:0]   occupancy;

  logic         b_hold, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]   b_in_data, b_out_data;
  logic [0:0]   b_stall, b_flush, b_stage_valid, b_occ;

  always #5 clk = ~clk;

  kamacore_pipeline_chain #(.DATA_W(W), .NUM_STAGES(N)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_hold(hold), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .i_in_data(in_data), .i_stall(stall), .i_flush(flush),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_stage_valid(stage_valid), .o_occupancy(occupancy)
  );

  kamacore_pipeline_chain #(.DATA_W(8), .NUM_STAGES(1)) u_one (
    .i_clk(clk), .i_rst(rst), .i_hold(b_hold), .i_in_valid(b_in_valid),
    .o_in_ready(b_in_ready), .i_in_data(b_in_data), .i_stall(b_stall), .i_flush(b_flush),
    .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_out_data(b_out_data),
    .o_stage_valid(b_stage_valid), .o_occupancy(b_occ)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: one occupancy flag and payload per slot.
  bit           m_v [N];
  logic [W-1:0] m_d [N];
  bit           e_in_ready, e_out_valid;
  int           cyc = 0;
  int           first_ov = -1;
  int           peak_occ = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A beat can be placed in slot j if, scanning toward the output, we reach
  // an empty or flushed slot, or the sink is ready. A stalled occupied slot
  // blocks the scan. Nothing moves under hold.
  function automatic bit room(input int j);
    if (hold) return 1'b0;
    for (int k = j; k < N; k++) begin
      if (!m_v[k] || flush[k]) return 1'b1;
      if (stall[k]) return 1'b0;
    end
    return out_ready;
  endfunction

  function automatic bit moves(input int i);
    return m_v[i] && !stall[i] && !flush[i] && room(i + 1);
  endfunction

  function automatic logic [N-1:0] m_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_v[i];
    return v;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_v[i]);
    return c;
  endfunction

  task automatic model_seq();
    bit           nv [N];
    logic [W-1:0] nd [N];
    bit           inc;
    for (int i = 0; i < N; i++) begin
      nv[i] = m_v[i];
      nd[i] = m_d[i];
      inc   = (i == 0) ? (in_valid && room(0)) : moves(i - 1);
      if (flush[i]) nv[i] = 1'b0;
      else if (room(i)) begin
        nv[i] = inc;
        if (inc) nd[i] = (i == 0) ? in_data : m_d[i-1];
      end
    end
    m_v = nv;
    m_d = nd;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 1'b0;
      m_d[i] = '0;
    end
    exp_q.delete();
  endtask

  // Inputs are already applied (posedge + 1). Predict, check at negedge,
  // then advance the model on the edge.
  task automatic cycle();
    e_in_ready  = room(0);
    e_out_valid = m_v[N-1] && !stall[N-1] && !flush[N-1] && !hold;
    if (e_out_valid && out_ready) exp_q.push_back(m_d[N-1]);
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(e_in_ready));
    chk("out_valid", 32'(out_valid), 32'(e_out_valid));
    chk("stage_valid", 32'(stage_valid), 32'(m_vec()));
    chk("occupancy", 32'(occupancy), 32'(m_count()));
    chk("out_data_reg", out_data, m_d[N-1]);
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (int'(occupancy) > peak_occ) peak_occ = int'(occupancy);
    @(posedge clk);
    model_seq();
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    hold = 0; in_valid = 0; in_data = '0; out_ready = 0; stall = '0; flush = '0;
  endtask

  // Monitor: every beat the DUT hands to the sink is popped and compared.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_beat_unexpected: got %0h expected none", out_data);
        end else begin
          chk("out_beat", out_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1;
    idle_inputs();
    b_hold = 0; b_in_valid = 0; b_in_data = '0; b_stall = '0; b_flush = '0; b_out_ready = 0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_stage_valid", 32'(stage_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    @(posedge clk);
    #1;

    // Streaming 0x1..0xA.
    out_ready = 1;
    first_ov = -1;
    peak_occ = 0;
    cyc = 0;
    for (int k = 1; k <= 10; k++) begin
      in_valid = 1;
      in_data = 32'(k);
      cycle();
    end
    in_valid = 0;
    for (int k = 0; k < 6; k++) cycle();
    chk("stream_latency", 32'(first_ov), 32'd4);
    chk("stream_peak_occ", 32'(peak_occ), 32'd4);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: fill with 1..4, then hold it back for 5 cycles.
    out_ready = 0;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1;
      in_data = 32'(k);
      cycle();
    end
    in_data = 32'h5;
    for (int k = 0; k < 5; k++) cycle();
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_data", out_data, 32'h1);
    chk("bp_occupancy", 32'(occupancy), 32'd4);
    out_ready = 1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    cycle();

    // Flush the two youngest stages while a beat is offered.
    out_ready = 0;
    flush = 4'b0011;
    in_data = 32'h6;
    cycle();
    flush = '0;
    in_valid = 0;
    out_ready = 1;
    for (int k = 0; k < 6; k++) cycle();

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      hold      = ($urandom % 16) == 0;
      in_valid  = ($urandom % 4) != 0;
      in_data   = $urandom;
      out_ready = ($urandom % 4) != 0;
      for (int s = 0; s < N; s++) begin
        stall[s] = ($urandom % 8) == 0;
        flush[s] = ($urandom % 32) == 0;
      end
      cycle();
    end

    // Hold mid-stream, then an asynchronous reset between edges.
    idle_inputs();
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1;
      in_data = $urandom;
      cycle();
    end
    hold = 1;
    for (int k = 0; k < 3; k++) cycle();
    hold = 0;
    #2;
    rst = 1;
    #1;
    chk("arst_stage_valid", 32'(stage_valid), 32'd0);
    chk("arst_occupancy", 32'(occupancy), 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    model_clear();
    idle_inputs();
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    out_ready = 1;
    for (int k = 0; k < N + 2; k++) cycle();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    // Single-stage chain with DATA_W=8.
    hold = 1;
    b_out_ready = 1;
    b_in_valid = 1;
    b_in_data = 8'hFF;
    #1;
    chk("one_in_ready_empty", 32'(b_in_ready), 32'd1);
    @(posedge clk);
    #1;
    b_in_valid = 0;
    b_stall = 1'b1;
    @(negedge clk);
    chk("one_stall_out_valid", 32'(b_out_valid), 32'd0);
    chk("one_stall_in_ready", 32'(b_in_ready), 32'd0);
    chk("one_stall_valid", 32'(b_stage_valid), 32'd1);
    @(posedge clk);
    #1;
    b_stall = 1'b0;
    @(negedge clk);
    chk("one_out_valid", 32'(b_out_valid), 32'd1);
    chk("one_out_data", 32'(b_out_data), 32'hFF);
    chk("one_in_ready", 32'(b_in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("one_drained", 32'(b_stage_valid), 32'd0);
    chk("one_occ", 32'(b_occ), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
